// File: rtl/iir_opti_pkg.sv
// Shared constants, coefficient set and controller state for the cascaded IIR filter.
// Default coefficients: section 0 is a leaky integrator (y = x + y1/2), the rest are unity pass-through.
package iir_opti_pkg;

  localparam int DW        = 24;
  localparam int FRAC      = 22;
  localparam int NUM_SOS   = 5;
  localparam int N_SAMPLES = 2048;
  localparam int ACC_W     = 51;
  localparam int AW        = $clog2(N_SAMPLES);

  typedef struct packed {
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic [DW-1:0] b2;
    logic [DW-1:0] a1;
    logic [DW-1:0] a2;
  } coef_t;

  localparam logic [DW-1:0] Q_ONE  = 24'h400000;
  localparam logic [DW-1:0] Q_MHALF = 24'hE00000;

  localparam coef_t PASS  = '{Q_ONE, 24'h0, 24'h0, 24'h0, 24'h0};
  localparam coef_t LEAKY = '{Q_ONE, 24'h0, 24'h0, Q_MHALF, 24'h0};

  localparam coef_t COEFS [NUM_SOS] = '{LEAKY, PASS, PASS, PASS, PASS};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/iir_sos_section.sv
// One Direct Form I biquad, one register stage; history advances only on in_vld.
// Rounds half-up; saturates when IIR_SAT_EN is defined, otherwise wraps to DW bits.
module iir_sos_section
  import iir_opti_pkg::*;
#(
  parameter coef_t COEF = PASS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_vld,
  input  logic [DW-1:0] in_dat,
  output logic          out_vld,
  output logic [DW-1:0] out_dat
);

  localparam int HW = ACC_W - FRAC;
  localparam logic signed [DW-1:0] B0 = COEF.b0;
  localparam logic signed [DW-1:0] B1 = COEF.b1;
  localparam logic signed [DW-1:0] B2 = COEF.b2;
  localparam logic signed [DW-1:0] A1 = COEF.a1;
  localparam logic signed [DW-1:0] A2 = COEF.a2;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC - 1);

  logic signed [DW-1:0]    x0, x1, x2, y1, y2;
  logic signed [2*DW-1:0]  p_b0, p_b1, p_b2, p_a1, p_a2;
  logic signed [ACC_W-1:0] acc, sum;
  logic signed [HW-1:0]    hi;
  logic [DW-1:0]           y;
  logic                    unused_bits;

  assign x0   = in_dat;
  assign p_b0 = (2*DW)'(x0) * (2*DW)'(B0);
  assign p_b1 = (2*DW)'(x1) * (2*DW)'(B1);
  assign p_b2 = (2*DW)'(x2) * (2*DW)'(B2);
  assign p_a1 = (2*DW)'(y1) * (2*DW)'(A1);
  assign p_a2 = (2*DW)'(y2) * (2*DW)'(A2);

  assign acc = ACC_W'(p_b0) + ACC_W'(p_b1) + ACC_W'(p_b2) - ACC_W'(p_a1) - ACC_W'(p_a2);
  assign sum = acc + RND;
  assign hi  = sum[ACC_W-1:FRAC];

`ifdef IIR_SAT_EN
  logic ovf;
  // Overflow when the bits above the DW-bit sign are not all copies of it.
  assign ovf = !((&hi[HW-1:DW-1]) || !(|hi[HW-1:DW-1]));
  assign y   = ovf ? {hi[HW-1], {(DW-1){~hi[HW-1]}}} : hi[DW-1:0];
  assign unused_bits = ^sum[FRAC-1:0];
`else
  assign y   = hi[DW-1:0];
  assign unused_bits = ^{sum[FRAC-1:0], hi[HW-1:DW]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else if (clr) begin
      x1 <= '0; x2 <= '0; y1 <= '0; y2 <= '0;
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        x1      <= x0;
        x2      <= x1;
        y1      <= y;
        y2      <= y1;
        out_dat <= y;
      end
    end
  end

endmodule

// File: rtl/iir_opti_top.sv
// Cascaded IIR top: run controller plus NUM_SOS biquads; sample in at edge k emerges at edge k+NUM_SOS+1.
// Optional IIR_SAT_EN selects per-section saturation instead of two's-complement wrap.
module iir_opti_top
  import iir_opti_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] data_in,
  input  logic          data_in_valid,
  output logic          filter_done,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_out,
  output logic          data_out_valid,
  output logic          stable_out
);

  state_t        state, state_nxt;
  logic          clr, accept, last_out;
  logic [AW:0]   in_cnt;
  logic [AW-1:0] out_cnt;
  logic          in_vld;
  logic [DW-1:0] in_dat;

  logic          chain_vld [NUM_SOS+1];
  logic [DW-1:0] chain_dat [NUM_SOS+1];

  assign last_out = (state == S_RUN) && chain_vld[NUM_SOS] && (out_cnt == AW'(N_SAMPLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          clr       = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        accept = data_in_valid && (in_cnt < (AW+1)'(N_SAMPLES));
        if (last_out) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_vld <= 1'b0;
      in_dat <= '0;
    end else begin
      in_vld <= accept;
      if (accept) in_dat <= data_in;
    end
  end

  assign chain_vld[0] = in_vld;
  assign chain_dat[0] = in_dat;

  for (genvar i = 0; i < NUM_SOS; i++) begin : g_sos
    iir_sos_section #(.COEF(COEFS[i])) u_sos (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (clr),
      .in_vld  (chain_vld[i]),
      .in_dat  (chain_dat[i]),
      .out_vld (chain_vld[i+1]),
      .out_dat (chain_dat[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_done    <= 1'b0;
      addr           <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      stable_out     <= 1'b0;
      out_cnt        <= '0;
      in_cnt         <= '0;
    end else begin
      filter_done    <= (state == S_DONE);
      data_out_valid <= chain_vld[NUM_SOS];
      if (chain_vld[NUM_SOS]) begin
        data_out <= chain_dat[NUM_SOS];
        addr     <= out_cnt;
        out_cnt  <= out_cnt + AW'(1);
      end
      if (accept) in_cnt <= in_cnt + (AW+1)'(1);
      // First sample entering the last section raises stable one clock ahead of the output.
      if (state == S_RUN && chain_vld[NUM_SOS-1]) stable_out <= 1'b1;
      if (state == S_DONE) stable_out <= 1'b0;
      if (clr) begin
        addr       <= '0;
        out_cnt    <= '0;
        in_cnt     <= '0;
        stable_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iir_opti_top.sv
// Directed self-checking bench for iir_opti_top using the default package coefficients.
module tb_iir_opti_top;
  import iir_opti_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_valid = 1'b0;
  logic          filter_done;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_out;
  logic          data_out_valid;
  logic          stable_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW-1:0] got_dat [$];
  logic [AW-1:0] got_addr [$];
  int            got_cyc [$];
  int            stable_cyc, done_cnt, done_cyc, vld_unstable;
  logic          stable_at_done, vld_at_done;

  always #5 clk = ~clk;

  iir_opti_top dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .filter_done    (filter_done),
    .addr           (addr),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .stable_out     (stable_out)
  );

  task automatic clear_log();
    got_dat.delete();
    got_addr.delete();
    got_cyc.delete();
    stable_cyc = -1;
    done_cnt = 0;
    done_cyc = -1;
    vld_unstable = 0;
    stable_at_done = 1'b1;
    vld_at_done = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (data_out_valid) begin
      got_dat.push_back(data_out);
      got_addr.push_back(addr);
      got_cyc.push_back(cyc);
      if (!stable_out) vld_unstable++;
    end
    if (stable_out && stable_cyc < 0) stable_cyc = cyc;
    if (filter_done) begin
      done_cnt++;
      done_cyc = cyc;
      stable_at_done = stable_out;
      vld_at_done = data_out_valid;
    end
  endtask

  task automatic feed(input logic [DW-1:0] d, input logic v);
    data_in = d;
    data_in_valid = v;
    tick();
  endtask

  task automatic drain(input int n);
    data_in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic restart();
    data_in_valid = 1'b0;
    start = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_log();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #2;
    checks++; if (filter_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", filter_done); end
    checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", addr); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", data_out); end
    checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
    checks++; if (stable_out !== 1'b0) begin errors++; $display("FAIL reset_stable: got %b expected 0", stable_out); end
    tick();
    rst_n = 1'b1;
    clear_log();
    for (int i = 0; i < 4; i++) feed(24'h111111, 1'b1);
    drain(10);
    checks++; if (got_dat.size() != 0) begin errors++; $display("FAIL idle_ignores_input: got %0d outputs expected 0", got_dat.size()); end
  endtask

  task automatic test_pass_through();
    int k, fc;
    restart();
    feed(24'h123456, 1'b1);
    k = cyc;
    drain(12);
    fc = (got_cyc.size() > 0) ? got_cyc[0] : -1;
    checks++; if (got_dat.size() != 1) begin errors++; $display("FAIL pt_count: got %0d expected 1", got_dat.size()); end
    checks++; if (fc - k != 6) begin errors++; $display("FAIL pt_latency: got %0d expected 6", fc - k); end
    checks++; if (stable_cyc - k != 5) begin errors++; $display("FAIL pt_stable_lead: got %0d expected 5", stable_cyc - k); end
    checks++; if ((got_dat.size() > 0 ? got_dat[0] : 24'hx) !== 24'h123456) begin errors++; $display("FAIL pt_data: got %h expected 123456", got_dat.size() > 0 ? got_dat[0] : 24'hx); end
    checks++; if ((got_addr.size() > 0 ? got_addr[0] : 11'hx) !== 11'h0) begin errors++; $display("FAIL pt_addr: got %h expected 0", got_addr.size() > 0 ? got_addr[0] : 11'hx); end
  endtask

  task automatic test_impulse();
    logic [DW-1:0] exp_imp [4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
    logic [DW-1:0] act;
    restart();
    feed(24'h400000, 1'b1);
    for (int i = 0; i < 3; i++) feed(24'h0, 1'b1);
    drain(12);
    for (int i = 0; i < 4; i++) begin
      act = (i < got_dat.size()) ? got_dat[i] : 24'hx;
      checks++; if (act !== exp_imp[i]) begin errors++; $display("FAIL impulse_%0d: got %h expected %h", i, act, exp_imp[i]); end
    end
  endtask

  task automatic test_saturation();
    logic [DW-1:0] exp_pos, exp_neg, act;
`ifdef IIR_SAT_EN
    exp_pos = 24'h7FFFFF;
    exp_neg = 24'h800000;
`else
    exp_pos = 24'hBFFFFF;
    exp_neg = 24'h400000;
`endif
    restart();
    feed(24'h7FFFFF, 1'b1);
    feed(24'h7FFFFF, 1'b1);
    drain(12);
    act = (got_dat.size() > 0) ? got_dat[0] : 24'hx;
    checks++; if (act !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos_first: got %h expected 7fffff", act); end
    act = (got_dat.size() > 1) ? got_dat[1] : 24'hx;
    checks++; if (act !== exp_pos) begin errors++; $display("FAIL sat_pos_second: got %h expected %h", act, exp_pos); end
    restart();
    feed(24'h800000, 1'b1);
    feed(24'h800000, 1'b1);
    drain(12);
    act = (got_dat.size() > 0) ? got_dat[0] : 24'hx;
    checks++; if (act !== 24'h800000) begin errors++; $display("FAIL sat_neg_first: got %h expected 800000", act); end
    act = (got_dat.size() > 1) ? got_dat[1] : 24'hx;
    checks++; if (act !== exp_neg) begin errors++; $display("FAIL sat_neg_second: got %h expected %h", act, exp_neg); end
  endtask

  task automatic test_valid_gaps();
    logic [DW-1:0] exp_imp [4] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000};
    logic [DW-1:0] act;
    logic [AW-1:0] act_a;
    int gap;
    restart();
    for (int i = 0; i < 4; i++) begin
      feed(exp_imp[0] & {DW{i == 0}}, 1'b1);
      feed(24'h555555, 1'b0);
    end
    drain(12);
    checks++; if (got_dat.size() != 4) begin errors++; $display("FAIL gap_count: got %0d expected 4", got_dat.size()); end
    for (int i = 0; i < 4; i++) begin
      act   = (i < got_dat.size()) ? got_dat[i] : 24'hx;
      act_a = (i < got_addr.size()) ? got_addr[i] : 11'hx;
      checks++; if (act !== exp_imp[i]) begin errors++; $display("FAIL gap_data_%0d: got %h expected %h", i, act, exp_imp[i]); end
      checks++; if (act_a !== AW'(i)) begin errors++; $display("FAIL gap_addr_%0d: got %h expected %h", i, act_a, AW'(i)); end
      if (i > 0) begin
        gap = (i < got_cyc.size()) ? got_cyc[i] - got_cyc[i-1] : -1;
        checks++; if (gap != 2) begin errors++; $display("FAIL gap_spacing_%0d: got %0d expected 2", i, gap); end
      end
    end
  endtask

  task automatic test_full_run();
    int bad, n, last_cyc;
    logic [DW-1:0] last_dat, act;
    logic [AW-1:0] last_addr;
    restart();
    for (int i = 0; i < N_SAMPLES + 10; i++) begin
      start = (i == 500);
      feed(24'h100000, 1'b1);
    end
    start = 1'b0;
    drain(40);
    n = got_dat.size();
    bad = 0;
    foreach (got_addr[i]) if (got_addr[i] !== AW'(i)) bad++;
    last_dat  = (n > 0) ? got_dat[n-1] : 24'hx;
    last_addr = (n > 0) ? got_addr[n-1] : 11'hx;
    last_cyc  = (n > 0) ? got_cyc[n-1] : -10;
    checks++; if (n != N_SAMPLES) begin errors++; $display("FAIL full_count: got %0d expected %0d", n, N_SAMPLES); end
    checks++; if (bad != 0) begin errors++; $display("FAIL full_addr_seq: got %0d bad expected 0", bad); end
    checks++; if (last_addr !== 11'h7FF) begin errors++; $display("FAIL full_last_addr: got %h expected 7ff", last_addr); end
    checks++; if (last_dat !== 24'h200000) begin errors++; $display("FAIL full_last_data: got %h expected 200000", last_dat); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_pulses: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != last_cyc + 1) begin errors++; $display("FAIL full_done_timing: got %0d expected %0d", done_cyc, last_cyc + 1); end
    checks++; if (stable_at_done !== 1'b0) begin errors++; $display("FAIL full_stable_at_done: got %b expected 0", stable_at_done); end
    checks++; if (vld_at_done !== 1'b0) begin errors++; $display("FAIL full_valid_at_done: got %b expected 0", vld_at_done); end
    checks++; if (vld_unstable != 0) begin errors++; $display("FAIL full_stable_through: got %0d unstable outputs expected 0", vld_unstable); end
    checks++; if (addr !== 11'h7FF) begin errors++; $display("FAIL full_addr_hold: got %h expected 7ff", addr); end
    // New run without reset: start alone must clear the history left by the previous run.
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_log();
    feed(24'h400000, 1'b1);
    drain(12);
    act = (got_dat.size() > 0) ? got_dat[0] : 24'hx;
    checks++; if (act !== 24'h400000) begin errors++; $display("FAIL start_clears_hist: got %h expected 400000", act); end
  endtask

  task automatic test_reset_mid_run();
    logic [DW-1:0] act;
    logic [AW-1:0] act_a;
    restart();
    for (int i = 0; i < 100; i++) feed(24'h400000, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if ({filter_done, data_out_valid, stable_out} !== 3'b000) begin errors++; $display("FAIL midrst_flags: got %b expected 000", {filter_done, data_out_valid, stable_out}); end
    checks++; if (data_out !== '0) begin errors++; $display("FAIL midrst_data: got %h expected 0", data_out); end
    checks++; if (addr !== '0) begin errors++; $display("FAIL midrst_addr: got %h expected 0", addr); end
    restart();
    feed(24'h400000, 1'b1);
    drain(12);
    act   = (got_dat.size() > 0) ? got_dat[0] : 24'hx;
    act_a = (got_addr.size() > 0) ? got_addr[0] : 11'hx;
    checks++; if (act !== 24'h400000) begin errors++; $display("FAIL midrst_fresh_data: got %h expected 400000", act); end
    checks++; if (act_a !== 11'h0) begin errors++; $display("FAIL midrst_fresh_addr: got %h expected 0", act_a); end
  endtask

  initial begin
    clear_log();
    test_reset();
    test_pass_through();
    test_impulse();
    test_saturation();
    test_valid_gaps();
    test_full_run();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
